ysyx_23060203_rd_arb: RTL and testbench
=======================================

YSYX_23060203_RD_ARB -- requirements
Module: ysyx_23060203_rd_arb

Interface
REQ-001 SHALL have parameter N_MST, default 2, number of AXI read masters, legal range 1..8.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, read data width.
REQ-004 SHALL have parameter RR_MODE, default 1, arbitration policy: 1 = round-robin, 0 = fixed priority with lowest index highest.
REQ-005 SHALL have ports as follows (one clock; reset asynchronous, active-high):
  clock       in   1          sole clock, all state on rising edge
  reset       in   1          asynchronous, active-high reset
  m_arvalid   in   N_MST      per-master AR valid
  m_arready   out  N_MST      per-master AR ready
  m_araddr    in   N_MST*AW   per-master address, master i at bits [i*AW +: AW]
  m_arid      in   N_MST*4    per-master ID
  m_arlen     in   N_MST*8    per-master burst length (beats-1)
  m_arsize    in   N_MST*3    per-master size
  m_arburst   in   N_MST*2    per-master burst type
  m_rvalid    out  N_MST      per-master R valid
  m_rready    in   N_MST      per-master R ready
  m_rdata     out  DW         R data, broadcast to all masters
  m_rresp     out  2          R resp, broadcast
  m_rlast     out  1          R last, broadcast
  m_rid       out  4          R id, broadcast
  s_arvalid   out  1          downstream AR valid
  s_arready   in   1          downstream AR ready
  s_araddr, s_arid, s_arlen, s_arsize, s_arburst   out   AW/4/8/3/2   downstream AR fields
  s_rvalid    in   1          downstream R valid
  s_rready    out  1          downstream R ready
  s_rdata, s_rresp, s_rlast, s_rid                 in    DW/2/1/4     downstream R fields
  grant       out  N_MST      registered one-hot grant, 0 when idle
  proto_err   out  1          sticky burst-length violation flag

Function
REQ-006 SHALL implement a 2-bit FSM with states IDLE, ADDR, and DATA; only one transaction is in flight at a time.
REQ-007 In IDLE with any m_arvalid high, SHALL register winner one-hot into grant and go to ADDR next cycle; otherwise stay IDLE.
REQ-008 In fixed mode, the winner SHALL be the lowest-index requester.
REQ-009 In RR mode, the winner SHALL be the first requester at index >= ptr, wrapping modulo N_MST; on each grant, ptr SHALL be set to (winner+1) mod N_MST.
REQ-010 In ADDR: s_arvalid=1; s_ar* SHALL equal the granted master's fields; m_arready[g]=s_arready; all other m_arready SHALL be 0.
REQ-011 On the s_arvalid&s_arready handshake, the FSM SHALL go to DATA, latch arlen into len_q, and clear beat counter cnt (8-bit).
REQ-012 In DATA: m_rvalid[g]=s_rvalid; s_rready=m_rready[g]; other m_rvalid=0; m_r* SHALL mirror s_r* combinationally.
REQ-013 Each s_rvalid&s_rready beat SHALL increment cnt; a beat with s_rlast=1 SHALL return the FSM to IDLE and clear grant.
REQ-014 SHALL set proto_err on a beat where (s_rlast=1 and cnt!=len_q) or (s_rlast=0 and cnt==len_q); the transaction SHALL still end only on rlast.
REQ-015 Arbitration SHALL NOT be re-evaluated in ADDR or DATA; a new higher-priority request waits.
REQ-016 In IDLE: s_arvalid, s_rready, all m_arready, and all m_rvalid SHALL be 0.
REQ-017 Minimum gap SHALL be one IDLE cycle between rlast and the next downstream s_arvalid.
REQ-018 With N_MST=1, ptr SHALL stay 0 and behaviour SHALL otherwise be identical.
REQ-019 SHALL add zero cycles of latency on R and on the AR handshake once in ADDR.

Reset
REQ-020 Reset assertion SHALL immediately force: state=IDLE, grant=0, ptr=0, cnt=0, len_q=0, proto_err=0; s_arvalid, s_rready, m_arready, m_rvalid low.
REQ-021 A transaction in progress at reset SHALL be abandoned; the first grant after release SHALL follow REQ-007..009 from ptr=0.

Verification
REQ-022 RR, N=2, both m_arvalid held from cycle 0, single-beat reads -> grants alternate 01,10,01,10; each s_arvalid is 1 cycle after IDLE.
REQ-023 Fixed mode, N=3, masters 1 and 2 request continuously -> master 1 always wins; master 2 never granted while master 1 requests.
REQ-024 Master 0 burst arlen=3, s_rvalid toggling, m_rready[0] stalls 2 cycles -> 4 beats delivered in order only to master 0; m_rvalid[1]=0 throughout; proto_err=0.
REQ-025 arlen=1 but slave asserts rlast on first beat -> proto_err=1 after that beat, FSM IDLE next cycle, proto_err stays 1 until reset.
REQ-026 Reset pulse in DATA mid-burst -> outputs low immediately; after release, a master-1 request (RR, N=2) is granted as 10 with ptr=0 arbitration.

Source files
------------

// File: rtl/ysyx_23060203_rd_arb.sv
// ysyx_23060203_rd_arb
// AXI read-channel arbiter: N_MST upstream read masters share one downstream
// read port. One transaction (AR handshake followed by its R burst) is in
// flight at a time. The winner is chosen in IDLE by round-robin or fixed
// priority, held in a registered one-hot grant until the beat carrying rlast.
// Beat counting against the captured arlen raises a sticky protocol flag
// when the slave's rlast disagrees with the requested length.

module ysyx_23060203_rd_arb #(
    parameter int N_MST   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 1
) (
    input  logic                clock,
    input  logic                reset,

    // upstream AR channels, master i in slice i
    input  logic [N_MST-1:0]    m_arvalid,
    output logic [N_MST-1:0]    m_arready,
    input  logic [N_MST*AW-1:0] m_araddr,
    input  logic [N_MST*4-1:0]  m_arid,
    input  logic [N_MST*8-1:0]  m_arlen,
    input  logic [N_MST*3-1:0]  m_arsize,
    input  logic [N_MST*2-1:0]  m_arburst,

    // upstream R channels, payload broadcast, valid steered
    output logic [N_MST-1:0]    m_rvalid,
    input  logic [N_MST-1:0]    m_rready,
    output logic [DW-1:0]       m_rdata,
    output logic [1:0]          m_rresp,
    output logic                m_rlast,
    output logic [3:0]          m_rid,

    // downstream AR channel
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [AW-1:0]       s_araddr,
    output logic [3:0]          s_arid,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,

    // downstream R channel
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DW-1:0]       s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    input  logic [3:0]          s_rid,

    // status
    output logic [N_MST-1:0]    grant,
    output logic                proto_err
);

    // Pointer width; a single master still needs one bit to hold the value 0.
    localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam logic [N_MST-1:0] ONE = N_MST'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N_MST-1:0] grant_q;
    logic [PW-1:0]    ptr_q;
    logic [7:0]       cnt_q;
    logic [7:0]       len_q;
    logic             err_q;

    logic [N_MST-1:0] win_oh;
    logic [PW-1:0]    win_idx;
    logic             any_req;
    logic             ar_hs;
    logic             r_beat;
    logic             len_bad;

    assign any_req = |m_arvalid;
    assign ar_hs   = (state_q == ADDR) && s_arready;
    assign r_beat  = (state_q == DATA) && s_rvalid && s_rready;
    // rlast early (count short of len) or missing (count already at len)
    assign len_bad = s_rlast ? (cnt_q != len_q) : (cnt_q == len_q);

    // R payload is a pure combinational mirror of the downstream channel.
    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;
    assign m_rid   = s_rid;

    assign grant     = grant_q;
    assign proto_err = err_q;

    // Arbitration: pick the winner among current requesters.
    // The loop walks from the farthest candidate to the nearest so that the
    // nearest requester (lowest offset from ptr, or lowest index) is the
    // last assignment and therefore wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // a path that skips the assignment infers a latch.
        win_oh  = '0;
        win_idx = '0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            if (RR_MODE != 0) begin
                if (|(m_arvalid & (ONE << ((int'(ptr_q) + k) % N_MST)))) begin
                    win_oh  = ONE << ((int'(ptr_q) + k) % N_MST);
                    win_idx = PW'((int'(ptr_q) + k) % N_MST);
                end
            end else if (m_arvalid[k]) begin
                win_oh  = ONE << k;
                win_idx = PW'(k);
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: arbitrate only in IDLE, then follow the transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ADDR;
            ADDR:    if (s_arready) state_d = DATA;
            DATA:    if (r_beat && s_rlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake steering toward the granted master only.
    always_comb begin
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        case (state_q)
            ADDR: begin
                s_arvalid = 1'b1;
                m_arready = grant_q & {N_MST{s_arready}};
            end
            DATA: begin
                s_rready = |(grant_q & m_rready);
                m_rvalid = grant_q & {N_MST{s_rvalid}};
            end
            default: ;
        endcase
    end

    // AR field mux: forward the granted master's address-channel fields.
    always_comb begin
        s_araddr  = '0;
        s_arid    = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        for (int k = 0; k < N_MST; k++) begin
            if (grant_q[k]) begin
                s_araddr  = m_araddr[k*AW +: AW];
                s_arid    = m_arid[k*4 +: 4];
                s_arlen   = m_arlen[k*8 +: 8];
                s_arsize  = m_arsize[k*3 +: 3];
                s_arburst = m_arburst[k*2 +: 2];
            end
        end
    end

    // Grant and round-robin pointer: loaded on arbitration, cleared on rlast.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            ptr_q   <= '0;
        end else if (state_q == IDLE && any_req) begin
            grant_q <= win_oh;
            if (RR_MODE != 0) begin
                ptr_q <= (win_idx == PW'(N_MST - 1)) ? '0 : win_idx + PW'(1);
            end
        end else if (r_beat && s_rlast) begin
            grant_q <= '0;
        end
    end

    // Burst bookkeeping: capture arlen at the AR handshake, count R beats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (ar_hs) begin
            len_q <= s_arlen;
            cnt_q <= '0;
        end else if (r_beat) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Sticky protocol flag: set on a beat whose rlast disagrees with the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 err_q <= 1'b0;
        else if (r_beat && len_bad) err_q <= 1'b1;
    end

endmodule

// File: tb/tb_ysyx_23060203_rd_arb.sv
// Testbench for ysyx_23060203_rd_arb: a round-robin two-master instance and a
// fixed-priority three-master instance, driven by randomized transactions and
// compared against a transaction-level reference model.

module tb_ysyx_23060203_rd_arb;

    logic clock;
    logic reset;

    // instance A: RR, N_MST=2
    logic [1:0]  a_arvalid, a_arready, a_rvalid, a_rready, a_grant;
    logic [63:0] a_araddr;
    logic [7:0]  a_arid;
    logic [15:0] a_arlen;
    logic [5:0]  a_arsize;
    logic [3:0]  a_arburst;
    logic [31:0] a_rdata;
    logic [1:0]  a_rresp;
    logic        a_rlast;
    logic [3:0]  a_rid;
    logic        a_s_arvalid, a_s_arready;
    logic [31:0] a_s_araddr;
    logic [3:0]  a_s_arid;
    logic [7:0]  a_s_arlen;
    logic [2:0]  a_s_arsize;
    logic [1:0]  a_s_arburst;
    logic        a_s_rvalid, a_s_rready;
    logic [31:0] a_s_rdata;
    logic [1:0]  a_s_rresp;
    logic        a_s_rlast;
    logic [3:0]  a_s_rid;
    logic        a_perr;

    // instance B: fixed priority, N_MST=3
    logic [2:0]  b_arvalid, b_arready, b_rvalid, b_rready, b_grant;
    logic [95:0] b_araddr;
    logic [11:0] b_arid;
    logic [23:0] b_arlen;
    logic [8:0]  b_arsize;
    logic [5:0]  b_arburst;
    logic [31:0] b_rdata;
    logic [1:0]  b_rresp;
    logic        b_rlast;
    logic [3:0]  b_rid;
    logic        b_s_arvalid, b_s_arready;
    logic [31:0] b_s_araddr;
    logic [3:0]  b_s_arid;
    logic [7:0]  b_s_arlen;
    logic [2:0]  b_s_arsize;
    logic [1:0]  b_s_arburst;
    logic        b_s_rvalid, b_s_rready;
    logic [31:0] b_s_rdata;
    logic [1:0]  b_s_rresp;
    logic        b_s_rlast;
    logic [3:0]  b_s_rid;
    logic        b_perr;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state for instance A
    int ptr_m = 0;
    bit err_m = 1'b0;

    ysyx_23060203_rd_arb #(.N_MST(2), .AW(32), .DW(32), .RR_MODE(1)) dut_a (
        .clock(clock), .reset(reset),
        .m_arvalid(a_arvalid), .m_arready(a_arready), .m_araddr(a_araddr),
        .m_arid(a_arid), .m_arlen(a_arlen), .m_arsize(a_arsize), .m_arburst(a_arburst),
        .m_rvalid(a_rvalid), .m_rready(a_rready), .m_rdata(a_rdata),
        .m_rresp(a_rresp), .m_rlast(a_rlast), .m_rid(a_rid),
        .s_arvalid(a_s_arvalid), .s_arready(a_s_arready), .s_araddr(a_s_araddr),
        .s_arid(a_s_arid), .s_arlen(a_s_arlen), .s_arsize(a_s_arsize), .s_arburst(a_s_arburst),
        .s_rvalid(a_s_rvalid), .s_rready(a_s_rready), .s_rdata(a_s_rdata),
        .s_rresp(a_s_rresp), .s_rlast(a_s_rlast), .s_rid(a_s_rid),
        .grant(a_grant), .proto_err(a_perr)
    );

    ysyx_23060203_rd_arb #(.N_MST(3), .AW(32), .DW(32), .RR_MODE(0)) dut_b (
        .clock(clock), .reset(reset),
        .m_arvalid(b_arvalid), .m_arready(b_arready), .m_araddr(b_araddr),
        .m_arid(b_arid), .m_arlen(b_arlen), .m_arsize(b_arsize), .m_arburst(b_arburst),
        .m_rvalid(b_rvalid), .m_rready(b_rready), .m_rdata(b_rdata),
        .m_rresp(b_rresp), .m_rlast(b_rlast), .m_rid(b_rid),
        .s_arvalid(b_s_arvalid), .s_arready(b_s_arready), .s_araddr(b_s_araddr),
        .s_arid(b_s_arid), .s_arlen(b_s_arlen), .s_arsize(b_s_arsize), .s_arburst(b_s_arburst),
        .s_rvalid(b_s_rvalid), .s_rready(b_s_rready), .s_rdata(b_s_rdata),
        .s_rresp(b_s_rresp), .s_rlast(b_s_rlast), .s_rid(b_s_rid),
        .grant(b_grant), .proto_err(b_perr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One complete transaction on instance A, starting in its IDLE cycle.
    // req: requesting masters; len: winner's arlen; beats: beats the slave
    // sends (rlast on the final one); pattern: scripted toggling/stall handshakes.
    task automatic run_a(input logic [1:0] req, input logic [7:0] len,
                         input int beats, input bit pattern);
        int         w;
        int         got;
        bit         done;
        logic [1:0] w_oh;
        logic [8:0] idle_got;
        logic [53:0] ar_got, ar_exp;
        logic [44:0] r_got, r_exp;

        // model: first requester at or after ptr, wrapping
        w = -1;
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = (ptr_m + k) % 2;
            if (w < 0 && req[idx]) w = idx;
        end
        w_oh = 2'b01 << w;

        @(negedge clock);
        a_arvalid   = req;
        a_araddr    = {$urandom, $urandom};
        a_arid      = 8'($urandom);
        a_arlen     = 16'($urandom);
        a_arlen[w*8 +: 8] = len;
        a_arsize    = 6'($urandom);
        a_arburst   = 4'($urandom);
        a_s_arready = 1'b0;
        a_s_rvalid  = 1'b0;
        a_s_rlast   = 1'b0;
        a_rready    = 2'($urandom);
        #1;
        idle_got = {a_grant, a_s_arvalid, a_s_rready, a_arready, a_rvalid, a_perr};
        tests_run++;
        if (idle_got !== {8'b0, err_m}) begin
            tests_failed++;
            $display("FAIL idle_state: got %b expected %b", idle_got, {8'b0, err_m});
        end

        // address phase
        done = 1'b0;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            @(negedge clock);
            a_s_arready = pattern ? (cyc >= 1) : 1'($urandom_range(0, 1));
            #1;
            ar_got = {a_grant, a_s_arvalid, a_arready, a_s_araddr, a_s_arid,
                      a_s_arlen, a_s_arsize, a_s_arburst};
            ar_exp = {w_oh, 1'b1, (a_s_arready ? w_oh : 2'b00), a_araddr[w*32 +: 32],
                      a_arid[w*4 +: 4], len, a_arsize[w*3 +: 3], a_arburst[w*2 +: 2]};
            tests_run++;
            if (ar_got !== ar_exp) begin
                tests_failed++;
                $display("FAIL addr_phase: got %h expected %h", ar_got, ar_exp);
            end
            if (a_s_arready) done = 1'b1;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL addr_timeout: got no handshake expected one within 50 cycles");
        end
        ptr_m = (w + 1) % 2;

        // data phase
        got  = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clock);
            a_s_arready = 1'b0;
            a_rready    = 2'($urandom);
            if (pattern) begin
                a_s_rvalid  = (cyc % 2 == 0);
                a_rready[w] = (cyc >= 2);
            end else begin
                a_s_rvalid = 1'($urandom_range(0, 1));
            end
            a_s_rdata = $urandom;
            a_s_rresp = 2'($urandom);
            a_s_rid   = 4'($urandom);
            a_s_rlast = (got == beats - 1);
            #1;
            r_got = {a_rvalid, a_s_rready, a_s_arvalid, a_arready,
                     a_rdata, a_rresp, a_rlast, a_rid};
            r_exp = {(a_s_rvalid ? w_oh : 2'b00), a_rready[w], 1'b0, 2'b00,
                     a_s_rdata, a_s_rresp, a_s_rlast, a_s_rid};
            tests_run++;
            if (r_got !== r_exp) begin
                tests_failed++;
                $display("FAIL data_phase: got %h expected %h", r_got, r_exp);
            end
            if (a_s_rvalid && a_rready[w]) begin
                if ((a_s_rlast && got != int'(len)) || (!a_s_rlast && got == int'(len)))
                    err_m = 1'b1;
                got++;
                if (a_s_rlast) done = 1'b1;
            end
        end
        tests_run++;
        if (got != beats) begin
            tests_failed++;
            $display("FAIL beat_count: got %0d expected %0d", got, beats);
        end
    endtask

    // Observe instance A in IDLE after the last transaction.
    task automatic check_a_idle(input string tag);
        logic [8:0] idle_got;
        @(negedge clock);
        a_s_rvalid  = 1'b0;
        a_s_rlast   = 1'b0;
        a_s_arready = 1'b0;
        a_arvalid   = 2'b00;
        #1;
        idle_got = {a_grant, a_s_arvalid, a_s_rready, a_arready, a_rvalid, a_perr};
        tests_run++;
        if (idle_got !== {8'b0, err_m}) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, idle_got, {8'b0, err_m});
        end
    endtask

    task automatic test_reset;
        logic [9:0] got_a;
        logic [9:0] got_b;
        reset = 1'b1;
        a_arvalid = 2'b11;  a_rready = 2'b11;  a_s_arready = 1'b1;  a_s_rvalid = 1'b1;
        b_arvalid = 3'b111; b_rready = 3'b111; b_s_arready = 1'b1;  b_s_rvalid = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        got_a = {1'b0, a_grant, a_s_arvalid, a_s_rready, a_arready, a_rvalid, a_perr};
        got_b = {b_grant, b_s_arvalid, b_s_rready, b_arready, b_perr};
        tests_run++;
        if (got_a !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_state_a: got %b expected 0", got_a);
        end
        tests_run++;
        if (got_b !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_state_b: got %b expected 0", got_b);
        end
        @(negedge clock);
        a_arvalid = '0; a_rready = '0; a_s_arready = 1'b0; a_s_rvalid = 1'b0;
        b_arvalid = '0; b_rready = '0; b_s_arready = 1'b0; b_s_rvalid = 1'b0;
        reset = 1'b0;
        ptr_m = 0;
        err_m = 1'b0;
    endtask

    // Both masters held valid, single-beat reads: grants alternate.
    task automatic test_rr_alternate;
        for (int i = 0; i < 4; i++) run_a(2'b11, 8'd0, 1, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            int beats;
            beats = $urandom_range(1, 4);
            run_a(2'($urandom_range(1, 3)), 8'(beats - 1), beats, 1'b0);
        end
    endtask

    // Four-beat burst to master 0 with toggling rvalid and a 2-cycle rready stall.
    task automatic test_burst_stall;
        run_a(2'b01, 8'd3, 4, 1'b1);
        check_a_idle("burst_stall_end");
    endtask

    // Fixed priority with three masters: lowest-index requester always wins.
    task automatic test_fixed;
        logic [3:0]  fi_got;
        logic [70:0] fa_got, fa_exp;
        logic [35:0] fd_got, fd_exp;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] req;
            logic [2:0] oh;
            int w;
            req = (i < 4) ? 3'b110 : 3'($urandom_range(1, 7));
            w = 0;
            for (int k = 2; k >= 0; k--) if (req[k]) w = k;
            oh = 3'b001 << w;

            @(negedge clock);
            b_arvalid   = req;
            b_araddr    = {$urandom, $urandom, $urandom};
            b_arid      = 12'($urandom);
            b_arlen     = 24'd0;
            b_s_arready = 1'b0;
            b_s_rvalid  = 1'b0;
            b_s_rlast   = 1'b0;
            b_rready    = 3'b111;
            #1;
            fi_got = {b_grant, b_s_arvalid};
            tests_run++;
            if (fi_got !== 4'b0) begin
                tests_failed++;
                $display("FAIL fixed_idle: got %b expected 0", fi_got);
            end

            @(negedge clock);
            b_s_arready = 1'b1;
            #1;
            fa_got = {b_grant, b_s_arvalid, b_arready, b_s_araddr, b_s_arid};
            fa_exp = {oh, 1'b1, oh, b_araddr[w*32 +: 32], b_arid[w*4 +: 4]};
            tests_run++;
            if (fa_got !== fa_exp) begin
                tests_failed++;
                $display("FAIL fixed_addr: got %h expected %h", fa_got, fa_exp);
            end

            @(negedge clock);
            b_s_arready = 1'b0;
            b_s_rvalid  = 1'b1;
            b_s_rlast   = 1'b1;
            b_s_rdata   = $urandom;
            #1;
            fd_got = {b_rvalid, b_s_rready, b_rdata};
            fd_exp = {oh, 1'b1, b_s_rdata};
            tests_run++;
            if (fd_got !== fd_exp) begin
                tests_failed++;
                $display("FAIL fixed_data: got %h expected %h", fd_got, fd_exp);
            end
        end
        @(negedge clock);
        b_arvalid = '0; b_s_rvalid = 1'b0; b_s_rlast = 1'b0;
        #1;
        fi_got = {b_grant, b_perr};
        tests_run++;
        if (fi_got !== 4'b0) begin
            tests_failed++;
            $display("FAIL fixed_end: got %b expected 0", fi_got);
        end
    endtask

    // arlen=1 but rlast on the first beat; the flag sticks across transactions.
    task automatic test_proto_err;
        run_a(2'b01, 8'd1, 1, 1'b0);
        run_a(2'b10, 8'd2, 3, 1'b0);
        check_a_idle("proto_err_sticky");
        tests_run++;
        if (a_perr !== 1'b1) begin
            tests_failed++;
            $display("FAIL proto_err_set: got %b expected 1", a_perr);
        end
    endtask

    // Reset mid-burst abandons the transaction and restarts arbitration from ptr=0.
    task automatic test_reset_mid_burst;
        logic [8:0] rs_got;
        @(negedge clock);
        a_arvalid   = 2'b01;
        a_arlen     = 16'h0003;
        a_s_arready = 1'b1;
        a_s_rvalid  = 1'b0;
        @(negedge clock);
        a_arvalid = 2'b00;
        @(negedge clock);
        a_s_arready = 1'b0;
        a_s_rvalid  = 1'b1;
        a_s_rlast   = 1'b0;
        a_rready    = 2'b11;
        @(negedge clock);
        #1;
        tests_run++;
        if (a_rvalid !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_burst_rvalid: got %b expected 01", a_rvalid);
        end
        reset = 1'b1;
        #1;
        rs_got = {a_grant, a_s_arvalid, a_s_rready, a_arready, a_rvalid, a_perr};
        tests_run++;
        if (rs_got !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs_low: got %b expected 0", rs_got);
        end
        @(negedge clock);
        reset      = 1'b0;
        a_s_rvalid = 1'b0;
        ptr_m      = 0;
        err_m      = 1'b0;
        run_a(2'b11, 8'd0, 1, 1'b0);
        run_a(2'b10, 8'd1, 2, 1'b0);
        check_a_idle("after_reset_end");
    endtask

    initial begin
        a_arvalid = '0; a_araddr = '0; a_arid = '0; a_arlen = '0; a_arsize = '0;
        a_arburst = '0; a_rready = '0; a_s_arready = 1'b0; a_s_rvalid = 1'b0;
        a_s_rdata = '0; a_s_rresp = '0; a_s_rlast = 1'b0; a_s_rid = '0;
        b_arvalid = '0; b_araddr = '0; b_arid = '0; b_arlen = '0; b_arsize = '0;
        b_arburst = '0; b_rready = '0; b_s_arready = 1'b0; b_s_rvalid = 1'b0;
        b_s_rdata = '0; b_s_rresp = '0; b_s_rlast = 1'b0; b_s_rid = '0;
        reset = 1'b1;

        test_reset;
        test_rr_alternate;
        test_random;
        test_burst_stall;
        test_fixed;
        test_proto_err;
        test_reset_mid_burst;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
